clk_div_multi: RTL

- Parametrised multi-channel successor of the single-channel integer clock divider.
- NUM_CH independent divided clocks are derived from one reference clock.
- Adds three things the single-channel divider lacks: glitch-free ratio and enable updates taken only at period boundaries, a common phase-sync restart, and a per-channel rising-edge strobe.
- Sits in the clock-generation block and feeds the UART TX/RX and peripheral clock domains.

---
 rtl/clk_div_multi.sv | 72 +++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: ratio/enable changes land only on period
// boundaries, a shared sync input restarts every channel, and each channel strobes o_tick.
module clk_div_multi #(
  parameter int NUM_CH   = 4,
  parameter int RATIO_WD = 8
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst,
  input  logic [NUM_CH-1:0]          i_clk_en,
  input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
  input  logic                       i_sync,
  output logic [NUM_CH-1:0]          o_div_clk,
  output logic [NUM_CH-1:0]          o_tick,
  output logic [NUM_CH*RATIO_WD-1:0] o_act_ratio
);

  localparam int                  WIDE_WD = RATIO_WD + 1;
  localparam logic [RATIO_WD-1:0] ONE     = RATIO_WD'(1);
  localparam logic [RATIO_WD:0]   ONE_W   = WIDE_WD'(1);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [RATIO_WD-1:0] act_q, act_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic                q_q, q_d;
    logic                tick_q, tick_d;
    logic [RATIO_WD-1:0] req;
    logic [RATIO_WD-1:0] req_norm;
    logic [RATIO_WD-1:0] cnt_inc;
    logic [RATIO_WD:0]   half;
    logic                boundary;

    // A ratio of 0 or 1 cannot be divided, so both collapse to bypass (act 0).
    always_comb begin
      req      = i_clk_en[k] ? i_div_ratio[k*RATIO_WD +: RATIO_WD] : '0;
      req_norm = (req > ONE) ? req : '0;
      cnt_inc  = cnt_q + ONE;
      half     = ({1'b0, act_q} + ONE_W) >> 1;
      boundary = i_sync || (act_q == '0) || (cnt_q == (act_q - ONE));

      act_d  = act_q;
      cnt_d  = cnt_inc;
      q_d    = ({1'b0, cnt_inc} < half);
      tick_d = 1'b0;
      if (boundary) begin
        act_d  = req_norm;
        cnt_d  = '0;
        q_d    = (req_norm != '0);
        tick_d = 1'b1;
      end
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        act_q  <= '0;
        cnt_q  <= '0;
        q_q    <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        cnt_q  <= cnt_d;
        q_q    <= q_d;
        tick_q <= tick_d;
      end
    end

    // Bypass passes the reference clock, but never while reset is held.
    assign o_div_clk[k]                         = (act_q == '0) ? (i_ref_clk & ~i_rst) : q_q;
    assign o_tick[k]                            = tick_q;
    assign o_act_ratio[k*RATIO_WD +: RATIO_WD]  = act_q;
  end

endmodule
